hub75_scan_engine: RTL and testbench



---
 rtl/hub75_scan_engine.sv | 132 +++++++++++++
 tb/tb_hub75_scan_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_engine.sv
// rtl/hub75_scan_engine.sv - HUB75 multi-chain BCM scan engine with double-buffered frame store
// Column shifting of plane n+1 overlaps the on-time of plane n; bank swaps land only at frame start.
module hub75_scan_engine #(
  parameter int CHAINS   = 2,
  parameter int ROW_BITS = 5,
  parameter int PLANES   = 8,
  parameter int COL_W    = 10,
  parameter int RD_LAT   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [COL_W-1:0]          pixels_per_row,
  input  logic [15:0]               base_time,
  input  logic [7:0]                blank_cycles,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic                      bank,
  output logic [ROW_BITS+COL_W:0]   rd_addr,
  output logic [2:0]                rd_plane,
  input  logic [6*CHAINS-1:0]       rd_data,
  output logic [6*CHAINS-1:0]       rgb,
  output logic                      led_clk,
  output logic                      latch_enable,
  output logic                      oe_n,
  output logic [ROW_BITS-1:0]       row_addr,
  output logic                      frame_sync,
  output logic                      busy
);

  localparam int OCW = 16 + PLANES - 1;
  localparam int TW  = COL_W + 2;
  localparam logic [2:0] LAST_PLANE = 3'(PLANES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, BLANK, LATCH} state_t;
  state_t state, next_state, after_wait;

  logic [TW-1:0]       tcnt;
  logic [7:0]          bcnt;
  logic [COL_W-1:0]    ppr_s;
  logic [15:0]         base_s;
  logic [7:0]          blank_s;
  logic [OCW-1:0]      on_cnt, on_cnt_nxt;
  logic [ROW_BITS-1:0] row, nxt_row;
  logic [2:0]          plane, nxt_plane;
  logic                start_shift, cap, rgb_vld, last_plane;
  logic [TW-1:0]       shift_last, lat_ph;
  logic [COL_W:0]      col_nxt;

  // tcnt counts cycles since SHIFT began; lat_ph is the same count seen at the RAM output.
  assign shift_last = {1'b0, ppr_s, 1'b0} + TW'(RD_LAT);
  assign lat_ph     = tcnt - TW'(RD_LAT);
  assign col_nxt    = tcnt[TW-1:1] + (COL_W+1)'(1);
  assign cap        = (state == SHIFT) && (tcnt >= TW'(RD_LAT)) && !lat_ph[0] &&
                      (lat_ph[TW-1:1] < {1'b0, ppr_s});
  assign last_plane = (plane == LAST_PLANE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    after_wait  = (blank_s != 8'd0) ? BLANK : LATCH;
    nxt_row     = row;
    nxt_plane   = plane;
    on_cnt_nxt  = on_cnt;
    case (state)
      IDLE:    if (enable && pixels_per_row != '0) next_state = SHIFT;
      SHIFT:   if (tcnt == shift_last) next_state = (on_cnt > OCW'(1)) ? WAIT : after_wait;
      WAIT:    if (on_cnt <= OCW'(1)) next_state = after_wait;
      BLANK:   if (bcnt == blank_s - 8'd1) next_state = LATCH;
      LATCH:   next_state = (enable && pixels_per_row != '0) ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
    start_shift = (next_state == SHIFT) && (state != SHIFT);
    if (state == LATCH) begin
      nxt_plane = last_plane ? 3'd0 : plane + 3'd1;
      nxt_row   = last_plane ? row + ROW_BITS'(1) : row;
    end
    // Leaving WAIT/SHIFT only once on_cnt hits 0 keeps the dark gap to BLANK+LATCH alone.
    if (state == LATCH && next_state == SHIFT) on_cnt_nxt = OCW'(base_s) << plane;
    else if (state == IDLE || next_state == IDLE) on_cnt_nxt = '0;
    else if (on_cnt != '0) on_cnt_nxt = on_cnt - OCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0; bcnt <= '0; ppr_s <= '0; base_s <= '0; blank_s <= '0;
      on_cnt <= '0; row <= '0; plane <= '0; rgb_vld <= 1'b0;
      swap_ack <= 1'b0; bank <= 1'b0; rd_addr <= '0; rd_plane <= '0;
      rgb <= '0; led_clk <= 1'b0; latch_enable <= 1'b0; oe_n <= 1'b1;
      row_addr <= '0; frame_sync <= 1'b0; busy <= 1'b0;
    end else begin
      on_cnt       <= on_cnt_nxt;
      oe_n         <= (on_cnt_nxt == '0) || (next_state == BLANK);
      busy         <= (next_state != IDLE);
      latch_enable <= (next_state == LATCH);
      frame_sync   <= (next_state == LATCH) && (row == {ROW_BITS{1'b1}}) && last_plane;
      swap_ack     <= 1'b0;
      rgb_vld      <= cap;
      led_clk      <= rgb_vld;
      if (cap) rgb <= rd_data;
      if (state == SHIFT) tcnt <= tcnt + TW'(1);
      if (state == BLANK) bcnt <= bcnt + 8'd1;
      if (next_state == BLANK && state != BLANK) bcnt <= '0;
      if (next_state == BLANK || next_state == LATCH) row_addr <= row;
      if (state == LATCH) begin
        row   <= nxt_row;
        plane <= nxt_plane;
      end
      if (start_shift) begin
        tcnt     <= '0;
        ppr_s    <= pixels_per_row;
        base_s   <= base_time;
        blank_s  <= blank_cycles;
        rd_plane <= nxt_plane;
        if (nxt_row == '0 && nxt_plane == 3'd0 && swap_req) begin
          bank     <= ~bank;
          swap_ack <= 1'b1;
          rd_addr  <= {~bank, nxt_row, {COL_W{1'b0}}};
        end else begin
          rd_addr  <= {bank, nxt_row, {COL_W{1'b0}}};
        end
      end else if (state == SHIFT && tcnt[0] && (col_nxt < {1'b0, ppr_s})) begin
        rd_addr[COL_W-1:0] <= col_nxt[COL_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_engine.sv
// tb/tb_hub75_scan_engine.sv - self-checking bench for hub75_scan_engine
// Timeline model predicts led/latch/oe/row events from base time, shift length and blank time.
module tb_hub75_scan_engine;
  localparam int CH = 2, RB = 1, PL = 2, CW = 10, RL = 2;
  localparam int AW = 1 + RB + CW, DW = 6 * CH, NROWS = 1 << RB;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, swap_req = 1'b0;
  logic [CW-1:0] ppr_in = '0;
  logic [15:0] base_in = '0;
  logic [7:0] blank_in = '0;
  logic swap_ack, bank, led_clk, latch_enable, oe_n, frame_sync, busy;
  logic [AW-1:0] rd_addr;
  logic [2:0] rd_plane;
  logic [DW-1:0] rd_data, rgb;
  logic [RB-1:0] row_addr;

  always #5 clk = ~clk;

  hub75_scan_engine #(.CHAINS(CH), .ROW_BITS(RB), .PLANES(PL), .COL_W(CW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pixels_per_row(ppr_in), .base_time(base_in),
    .blank_cycles(blank_in), .swap_req(swap_req), .swap_ack(swap_ack), .bank(bank),
    .rd_addr(rd_addr), .rd_plane(rd_plane), .rd_data(rd_data), .rgb(rgb), .led_clk(led_clk),
    .latch_enable(latch_enable), .oe_n(oe_n), .row_addr(row_addr), .frame_sync(frame_sync),
    .busy(busy));

  // Framebuffer: returns the address itself, RL cycles later.
  logic [AW-1:0] rpipe [RL];
  always @(posedge clk) begin
    rpipe[0] <= rd_addr;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rd_data = DW'(rpipe[RL-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [DW-1:0] d;} ev_t;
  typedef struct {int cyc; int row; int plane; bit fs; bit bk;} lat_t;
  typedef struct {int ppr; int base; int blank; int lat0; int lat1; int oe0; int oe1;} vec_t;

  ev_t  led_q[$], exp_led[$], ra_q[$], exp_ra[$];
  lat_t lat_q[$], exp_lat[$];
  int   oe_q[$], exp_oe[$], ack_q[$];
  int   oe_run = 0, stray_fs = 0;
  logic [RB-1:0] prev_ra = '0;
  int   n_err = 0, n_chk = 0;

  always @(negedge clk) begin
    if (led_clk === 1'b1) led_q.push_back('{cyc, rgb});
    if (latch_enable === 1'b1)
      lat_q.push_back('{cyc, int'(row_addr), int'(rd_plane), frame_sync, bank});
    if (frame_sync === 1'b1 && latch_enable !== 1'b1) stray_fs++;
    if (swap_ack === 1'b1) ack_q.push_back(cyc);
    if (oe_n === 1'b0) oe_run++;
    else if (oe_run > 0) begin oe_q.push_back(oe_run); oe_run = 0; end
    if (row_addr !== prev_ra) begin ra_q.push_back('{cyc, DW'(row_addr)}); prev_ra = row_addr; end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(int b, int r, int k);
    return DW'((b << (RB + CW)) | (r << CW) | k);
  endfunction

  // Plane period = max(shift length, pending on-time) + blank + 1; on-time = base << plane.
  task automatic model(int s, int ppr, int base, int blank, int n);
    int st, on, r, p, len, lat, ra;
    exp_led.delete(); exp_lat.delete(); exp_oe.delete(); exp_ra.delete();
    st = s; on = 0; r = 0; p = 0; ra = 0;
    for (int i = 0; i < n; i++) begin
      len = 2 * ppr + RL + 1;
      for (int k = 0; k < ppr; k++) exp_led.push_back('{st + RL + 2 + 2 * k, mk_data(0, r, k)});
      lat = st + ((len > on) ? len : on) + blank;
      if (r != ra) begin exp_ra.push_back('{lat - blank, DW'(r)}); ra = r; end
      exp_lat.push_back('{lat, r, p, (r == NROWS - 1) && (p == PL - 1), 1'b0});
      on = base << p;
      if (on != 0 && i < n - 1) exp_oe.push_back(on);
      st = lat + 1;
      if (p == PL - 1) begin p = 0; r = (r + 1) % NROWS; end
      else p++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; swap_req = 1'b0;
    repeat (3) @(negedge clk);
    led_q.delete(); lat_q.delete(); oe_q.delete(); ra_q.delete(); ack_q.delete();
    stray_fs = 0;
    reset = 1'b0;
  endtask

  task automatic start(int ppr, int base, int blank, output int s);
    int c = 0;
    ppr_in = CW'(ppr); base_in = 16'(base); blank_in = 8'(blank);
    enable = 1'b1;
    while (busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    chk("start_busy", busy, 1);
    s = cyc;
    chk("first_rd_addr", rd_addr, 0);
    chk("first_rd_plane", rd_plane, 0);
  endtask

  task automatic wait_lat(int n, string tag);
    int c = 0;
    while (lat_q.size() < n && c < 5000) begin @(negedge clk); c++; end
    chk({tag, "_latch_wait"}, lat_q.size() >= n, 1);
  endtask

  task automatic compare(string tag);
    int lastlat, nled;
    lastlat = exp_lat[exp_lat.size()-1].cyc;
    nled = 0;
    for (int i = 0; i < exp_lat.size() && i < lat_q.size(); i++) begin
      chk($sformatf("%s_lat%0d_cyc", tag, i), lat_q[i].cyc, exp_lat[i].cyc);
      chk($sformatf("%s_lat%0d_row", tag, i), lat_q[i].row, exp_lat[i].row);
      chk($sformatf("%s_lat%0d_plane", tag, i), lat_q[i].plane, exp_lat[i].plane);
      chk($sformatf("%s_lat%0d_fs", tag, i), lat_q[i].fs, exp_lat[i].fs);
    end
    foreach (led_q[i]) if (led_q[i].cyc <= lastlat) nled++;
    chk({tag, "_led_count"}, nled, exp_led.size());
    for (int i = 0; i < exp_led.size() && i < led_q.size(); i++) begin
      chk($sformatf("%s_led%0d_cyc", tag, i), led_q[i].cyc, exp_led[i].cyc);
      chk($sformatf("%s_led%0d_rgb", tag, i), led_q[i].d, exp_led[i].d);
    end
    chk({tag, "_oe_count"}, oe_q.size() >= exp_oe.size(), 1);
    for (int i = 0; i < exp_oe.size() && i < oe_q.size(); i++)
      chk($sformatf("%s_oe%0d_len", tag, i), oe_q[i], exp_oe[i]);
    chk({tag, "_ra_count"}, ra_q.size() >= exp_ra.size(), 1);
    for (int i = 0; i < exp_ra.size() && i < ra_q.size(); i++) begin
      chk($sformatf("%s_ra%0d_cyc", tag, i), ra_q[i].cyc, exp_ra[i].cyc);
      chk($sformatf("%s_ra%0d_val", tag, i), ra_q[i].d, exp_ra[i].d);
    end
    chk({tag, "_stray_frame_sync"}, stray_fs, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int s, target, c, idle_bad, ppr, base, blank;
    tbl[0] = '{4, 20, 2, 13, 36, 20, 40};
    tbl[1] = '{1, 0, 0, 5, 11, 0, 0};
    tbl[2] = '{3, 100, 0, 9, 110, 100, 200};
    tbl[3] = '{2, 1, 1, 8, 17, 1, 2};

    // Reset mid-SHIFT of plane 1 while the plane-0 on-time is running.
    do_reset();
    chk("reset_oe_n", oe_n, 1);
    chk("reset_outs", {swap_ack, bank, rd_addr, rd_plane, rgb, led_clk, latch_enable,
                       row_addr, frame_sync, busy}, 0);
    start(4, 20, 2, s);
    wait_lat(1, "rst");
    repeat (6) @(negedge clk);
    chk("pre_reset_oe_n", oe_n, 0);
    chk("pre_reset_rd_plane", rd_plane, 1);
    chk("pre_reset_rgb", rgb, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_oe_n", oe_n, 1);
    chk("midrun_reset_outs", {swap_ack, bank, rd_addr, rd_plane, rgb, led_clk, latch_enable,
                              row_addr, frame_sync, busy}, 0);

    // Table-driven configurations with hand-derived latch times and on-times.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      start(tbl[t].ppr, tbl[t].base, tbl[t].blank, s);
      model(s, tbl[t].ppr, tbl[t].base, tbl[t].blank, 4);
      wait_lat(4, $sformatf("tbl%0d", t));
      if (lat_q.size() >= 2) begin
        chk($sformatf("tbl%0d_lat0_off", t), lat_q[0].cyc - s, tbl[t].lat0);
        chk($sformatf("tbl%0d_lat1_off", t), lat_q[1].cyc - s, tbl[t].lat1);
      end
      if (tbl[t].oe0 == 0) chk($sformatf("tbl%0d_oe_never_low", t), oe_q.size(), 0);
      else if (oe_q.size() >= 2) begin
        chk($sformatf("tbl%0d_oe0", t), oe_q[0], tbl[t].oe0);
        chk($sformatf("tbl%0d_oe1", t), oe_q[1], tbl[t].oe1);
      end
      compare($sformatf("tbl%0d", t));
    end

    // Randomized configurations against the timeline model.
    for (int t = 0; t < 6; t++) begin
      ppr = $urandom_range(1, 6); base = $urandom_range(0, 40); blank = $urandom_range(0, 3);
      do_reset();
      start(ppr, base, blank, s);
      model(s, ppr, base, blank, 6);
      wait_lat(6, $sformatf("rnd%0d", t));
      compare($sformatf("rnd%0d", t));
    end

    // Bank swap requested mid-frame lands at the next (row 0, plane 0) shift.
    do_reset();
    start(2, 4, 1, s);
    model(s, 2, 4, 1, 8);
    wait_lat(1, "swap");
    swap_req = 1'b1;
    target = exp_lat[3].cyc;
    c = 0;
    while (cyc < target && c < 5000) begin @(negedge clk); c++; end
    chk("swap_bank_before", bank, 0);
    chk("swap_ack_before", swap_ack, 0);
    @(negedge clk);
    chk("swap_bank_after", bank, 1);
    chk("swap_ack_pulse", swap_ack, 1);
    chk("swap_rd_addr_msb", rd_addr[AW-1], 1);
    swap_req = 1'b0;
    @(negedge clk);
    chk("swap_ack_drop", swap_ack, 0);
    wait_lat(8, "swap");
    chk("swap_ack_count", ack_q.size(), 1);
    if (ack_q.size() > 0) chk("swap_ack_cyc", ack_q[0], target + 1);
    for (int i = 0; i < 8 && i < lat_q.size(); i++) begin
      chk($sformatf("swap_lat%0d_bank", i), lat_q[i].bk, i >= 4);
      chk($sformatf("swap_lat%0d_cyc", i), lat_q[i].cyc, exp_lat[i].cyc);
    end
    chk("swap_rd_addr_msb_later", rd_addr[AW-1], 1);

    // Disable during SHIFT: that plane still latches, then IDLE; resume at next plane.
    do_reset();
    start(4, 20, 2, s);
    model(s, 4, 20, 2, 3);
    wait_lat(1, "dis");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_lat(2, "dis");
    if (lat_q.size() >= 2) begin
      chk("dis_lat1_cyc", lat_q[1].cyc, exp_lat[1].cyc);
      chk("dis_lat1_plane", lat_q[1].plane, 1);
    end
    @(negedge clk);
    chk("dis_busy", busy, 0);
    chk("dis_oe_n", oe_n, 1);
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (oe_n !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    chk("dis_idle_stable", idle_bad, 0);
    chk("dis_no_extra_latch", lat_q.size(), 2);
    enable = 1'b1;
    wait_lat(3, "dis");
    if (lat_q.size() >= 3) begin
      chk("dis_resume_row", lat_q[2].row, 1);
      chk("dis_resume_plane", lat_q[2].plane, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
